// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle accumulator/register CPU controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_JMP, S_ALU_EX, S_ALU_WB, S_ADDR, S_LD_MEM,
    S_MOP_RD, S_MOP_WB, S_ST, S_DI, S_HALT, S_FAULT
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADDM  = 3'b010;
  localparam logic [2:0] OP_ANDM  = 3'b011;
  localparam logic [2:0] OP_ALU0  = 3'b100;
  localparam logic [2:0] OP_ALU1  = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_SYS   = 3'b111;

  localparam logic [1:0] SUB_MOV = 2'b00;
  localparam logic [1:0] SUB_ADD = 2'b01;
  localparam logic [1:0] SUB_AND = 2'b10;
  localparam logic [1:0] SUB_OR  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] COND_ALW = 2'b00;
  localparam logic [1:0] COND_Z   = 2'b01;
  localparam logic [1:0] COND_C   = 2'b10;
  localparam logic [1:0] COND_N   = 2'b11;

  // czn is packed {C,Z,N}
  function automatic logic cond_met(input logic [1:0] f, input logic [2:0] czn);
    case (f)
      COND_ALW: return 1'b1;
      COND_Z:   return czn[1];
      COND_C:   return czn[2];
      COND_N:   return czn[0];
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// Counts consecutive cycles stalled on mem_ready and flags a timeout at TO_MAX.
module ctrl_mem_timer #(
  parameter int TO_W   = 4,
  parameter int TO_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  logic [TO_W-1:0] cnt;

  assign timeout = waiting && !mem_ready && (cnt == TO_W'(TO_MAX));

  // Every wait state exits on mem_ready or timeout, so anything but a stall clears.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (waiting && !mem_ready && !timeout)
      cnt <= cnt + TO_W'(1);
    else
      cnt <= '0;
  end

endmodule

// File: rtl/multicycle_ctrl_p.sv
// Multicycle control FSM: datapath strobes, memory handshake with timeout,
// conditional jumps, HALT and a retired-instruction counter.
module multicycle_ctrl_p
  import ctrl_pkg::*;
#(
  parameter int IW       = 8,
  parameter int ALU_OP_W = 2,
  parameter int TO_W     = 4,
  parameter int TO_MAX   = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IW-1:0]       ins,
  input  logic [2:0]          czn,
  input  logic                mem_ready,
  output logic                selA,
  output logic                selB,
  output logic                IorD,
  output logic                memRead,
  output logic                memWrite,
  output logic                pcWrite,
  output logic                IRld,
  output logic                TRld,
  output logic                MDRld,
  output logic                DIld,
  output logic                CZNld,
  output logic                regWrite,
  output logic                RA2sel,
  output logic                WAsel,
  output logic                WDsel,
  output logic                jmpSignal,
  output logic [ALU_OP_W-1:0] aluOp,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    retired
);

  state_t     state;
  logic [2:0] op;
  logic [1:0] f, sub;
  logic       sys_halt, waiting, timeout, jmp_take, unused_ins;
  logic [1:0] alu_sel, mop_sel;

  assign op         = ins[IW-1 -: 3];
  assign f          = ins[IW-4 -: 2];
  assign sub        = ins[IW-3 -: 2];
  assign sys_halt   = ins[IW-4];
  assign unused_ins = ^ins[IW-6:0];
  assign jmp_take   = cond_met(f, czn);
  assign waiting    = state inside {S_IF, S_LD_MEM, S_MOP_RD, S_ST};
  assign mop_sel    = (op == OP_ANDM) ? ALU_AND : ALU_ADD;

  always_comb begin
    alu_sel = ALU_ADD;
    case (sub)
      SUB_MOV, SUB_ADD: alu_sel = ALU_ADD;
      SUB_AND:          alu_sel = ALU_AND;
      SUB_OR:           alu_sel = ALU_OR;
      default:          alu_sel = ALU_ADD;
    endcase
  end

  ctrl_mem_timer #(.TO_W(TO_W), .TO_MAX(TO_MAX)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // retired counts at each instruction's final-state exit, and on HALT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IF;
      retired <= '0;
    end else begin
      case (state)
        S_IF:
          if (mem_ready)    state <= S_ID;
          else if (timeout) state <= S_FAULT;
        S_ID:
          case (op)
            OP_LOAD, OP_ADDM, OP_ANDM: state <= S_ADDR;
            OP_STORE:                  state <= S_ST;
            OP_ALU0, OP_ALU1:          state <= S_ALU_EX;
            OP_JMP:                    state <= S_JMP;
            OP_SYS:
              if (sys_halt) begin
                state   <= S_HALT;
                retired <= retired + CNT_W'(1);
              end else begin
                state   <= S_DI;
              end
            default:                   state <= S_IF;
          endcase
        S_JMP, S_ALU_WB, S_MOP_WB, S_DI: begin
          state   <= S_IF;
          retired <= retired + CNT_W'(1);
        end
        S_ALU_EX: state <= S_ALU_WB;
        S_ADDR:   state <= (op == OP_LOAD) ? S_LD_MEM : S_MOP_RD;
        S_LD_MEM, S_ST:
          if (mem_ready) begin
            state   <= S_IF;
            retired <= retired + CNT_W'(1);
          end else if (timeout) begin
            state   <= S_FAULT;
          end
        S_MOP_RD:
          if (mem_ready)    state <= S_MOP_WB;
          else if (timeout) state <= S_FAULT;
        S_HALT, S_FAULT: state <= state;
        default:         state <= S_IF;
      endcase
    end
  end

  always_comb begin
    {selA, selB, IorD, memRead, memWrite, pcWrite, IRld, TRld,
     MDRld, DIld, CZNld, regWrite, RA2sel, WAsel, WDsel, jmpSignal} = '0;
    aluOp  = '0;
    halted = 1'b0;
    fault  = 1'b0;
    if (!rst) begin
      case (state)
        S_IF: begin
          memRead = 1'b1;
          IRld    = mem_ready;
          pcWrite = mem_ready;
        end
        S_ID: begin
          TRld    = (op == OP_LOAD) || (op == OP_ADDM) || (op == OP_ANDM);
          memRead = (op == OP_JMP);
        end
        S_JMP: begin
          TRld      = 1'b1;
          jmpSignal = jmp_take;
          pcWrite   = jmp_take;
        end
        S_ALU_EX: begin
          selA  = 1'b1;
          selB  = (sub == SUB_MOV);
          WDsel = 1'b1;
          aluOp = ALU_OP_W'(alu_sel);
        end
        S_ALU_WB: begin
          selA     = 1'b1;
          selB     = (sub == SUB_MOV);
          regWrite = 1'b1;
          CZNld    = 1'b1;
          aluOp    = ALU_OP_W'(alu_sel);
        end
        S_ADDR: TRld = 1'b1;
        S_LD_MEM: begin
          {IorD, memRead, MDRld, RA2sel, WAsel} = '1;
          regWrite = mem_ready;
        end
        S_MOP_RD: begin
          {IorD, memRead, MDRld, RA2sel, WAsel, WDsel} = '1;
          aluOp = ALU_OP_W'(mop_sel);
        end
        S_MOP_WB: begin
          regWrite = 1'b1;
          CZNld    = 1'b1;
          aluOp    = ALU_OP_W'(mop_sel);
        end
        S_ST:     {TRld, selB, IorD, memWrite} = '1;
        S_DI:     DIld   = 1'b1;
        S_HALT:   halted = 1'b1;
        S_FAULT:  fault  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_p.sv
// Scoreboard bench: the driver queues hand-computed expected outputs per cycle,
// a monitor on the falling edge pops and compares both DUT instances.
module tb_multicycle_ctrl_p;

  typedef struct packed {
    logic [15:0] s;
    logic [1:0]  alu;
    logic        h;
    logic        f;
    logic [15:0] ret;
  } out_t;

  localparam logic [15:0] SELA = 16'h8000, SELB = 16'h4000, IORD = 16'h2000, MRD = 16'h1000;
  localparam logic [15:0] MWR = 16'h0800, PCW = 16'h0400, IRLD = 16'h0200, TRLD = 16'h0100;
  localparam logic [15:0] MDRLD = 16'h0080, DILD = 16'h0040, CZNLD = 16'h0020, REGW = 16'h0010;
  localparam logic [15:0] RA2 = 16'h0008, WAS = 16'h0004, WDS = 16'h0002, JMPS = 16'h0001;
  localparam logic [15:0] FETCH = MRD | IRLD | PCW;
  localparam logic [15:0] LDM   = IORD | MRD | MDRLD | RA2 | WAS;
  localparam logic [15:0] MOPR  = LDM | WDS;
  localparam logic [15:0] STS   = TRLD | SELB | IORD | MWR;

  logic        clk, rst, mem_ready;
  logic [7:0]  ins;
  logic [2:0]  czn;
  logic [15:0] sm, sw;
  logic [1:0]  aluOp, aluOp_w;
  logic        halted, fault, halted_w, fault_w;
  logic [15:0] retired;
  logic [3:0]  retired_w;

  out_t        expq[$];
  string       nameq[$];
  logic [15:0] exp_ret;
  int          nvec, nerr;

  multicycle_ctrl_p dut (
    .clk(clk), .rst(rst), .ins(ins), .czn(czn), .mem_ready(mem_ready),
    .selA(sm[15]), .selB(sm[14]), .IorD(sm[13]), .memRead(sm[12]), .memWrite(sm[11]),
    .pcWrite(sm[10]), .IRld(sm[9]), .TRld(sm[8]), .MDRld(sm[7]), .DIld(sm[6]),
    .CZNld(sm[5]), .regWrite(sm[4]), .RA2sel(sm[3]), .WAsel(sm[2]), .WDsel(sm[1]),
    .jmpSignal(sm[0]), .aluOp(aluOp), .halted(halted), .fault(fault), .retired(retired)
  );

  multicycle_ctrl_p #(.CNT_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .ins(ins), .czn(czn), .mem_ready(mem_ready),
    .selA(sw[15]), .selB(sw[14]), .IorD(sw[13]), .memRead(sw[12]), .memWrite(sw[11]),
    .pcWrite(sw[10]), .IRld(sw[9]), .TRld(sw[8]), .MDRld(sw[7]), .DIld(sw[6]),
    .CZNld(sw[5]), .regWrite(sw[4]), .RA2sel(sw[3]), .WAsel(sw[2]), .WDsel(sw[1]),
    .jmpSignal(sw[0]), .aluOp(aluOp_w), .halted(halted_w), .fault(fault_w), .retired(retired_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [7:0] i, input logic [2:0] c,
                               input logic m, input logic [15:0] s, input logic [1:0] a,
                               input logic [1:0] hf, input string nm);
    out_t e;
    @(posedge clk);
    #1;
    rst = r; ins = i; czn = c; mem_ready = m;
    e.s = s; e.alu = a; e.h = hf[1]; e.f = hf[0]; e.ret = exp_ret;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  task automatic checkOutput(input out_t e, input string nm);
    out_t act, acts, es;
    act  = {sm, aluOp, halted, fault, retired};
    acts = {sw, aluOp_w, halted_w, fault_w, 12'h000, retired_w};
    es   = e;
    es.ret = {12'h000, e.ret[3:0]};
    nvec++;
    if (act !== e || acts !== es) begin
      nerr++;
      $display("[TB] FAIL %s: got main=%h wrap=%h, want main=%h wrap=%h", nm, act, acts, e, es);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) checkOutput(expq.pop_front(), nameq.pop_front());
    end
  end

  task automatic runAlu(input logic [7:0] i, input logic [15:0] bsel, input logic [1:0] a,
                        input string nm);
    applyStimulus(0, i, 3'b000, 1, FETCH, 2'b00, 2'b00, {nm, "_if"});
    applyStimulus(0, i, 3'b000, 1, 16'h0000, 2'b00, 2'b00, {nm, "_id"});
    applyStimulus(0, i, 3'b000, 1, SELA | WDS | bsel, a, 2'b00, {nm, "_ex"});
    applyStimulus(0, i, 3'b000, 1, SELA | REGW | CZNLD | bsel, a, 2'b00, {nm, "_wb"});
    exp_ret++;
  endtask

  task automatic runMop(input logic [7:0] i, input logic [1:0] a, input string nm);
    applyStimulus(0, i, 3'b000, 1, FETCH, 2'b00, 2'b00, {nm, "_if"});
    applyStimulus(0, i, 3'b000, 0, TRLD, 2'b00, 2'b00, {nm, "_id"});
    applyStimulus(0, i, 3'b000, 1, TRLD, 2'b00, 2'b00, {nm, "_addr"});
    applyStimulus(0, i, 3'b000, 0, MOPR, a, 2'b00, {nm, "_rd_wait"});
    applyStimulus(0, i, 3'b000, 1, MOPR, a, 2'b00, {nm, "_rd"});
    applyStimulus(0, i, 3'b000, 0, REGW | CZNLD, a, 2'b00, {nm, "_wb"});
    exp_ret++;
  endtask

  task automatic runJmp(input logic [7:0] i, input logic [2:0] c, input logic taken,
                        input string nm);
    applyStimulus(0, i, c, 1, FETCH, 2'b00, 2'b00, {nm, "_if"});
    applyStimulus(0, i, c, 1, MRD, 2'b00, 2'b00, {nm, "_id"});
    applyStimulus(0, i, c, 1, taken ? (TRLD | JMPS | PCW) : TRLD, 2'b00, 2'b00, {nm, "_jmp"});
    exp_ret++;
  endtask

  initial begin
    rst = 1'b1; ins = 8'h00; czn = 3'b000; mem_ready = 1'b0;
    exp_ret = 16'h0000; nvec = 0; nerr = 0;

    applyStimulus(1, 8'h00, 3'b000, 1, 16'h0000, 2'b00, 2'b00, "reset");

    runAlu(8'h90, 16'h0000, 2'b00, "add");
    runAlu(8'h80, SELB,     2'b00, "mov");
    runAlu(8'hA0, 16'h0000, 2'b01, "and");
    runAlu(8'hB0, 16'h0000, 2'b10, "or");

    applyStimulus(0, 8'h00, 3'b000, 0, MRD, 2'b00, 2'b00, "load_if_wait");
    applyStimulus(0, 8'h00, 3'b000, 1, FETCH, 2'b00, 2'b00, "load_if");
    applyStimulus(0, 8'h00, 3'b000, 0, TRLD, 2'b00, 2'b00, "load_id");
    applyStimulus(0, 8'h00, 3'b000, 0, TRLD, 2'b00, 2'b00, "load_addr");
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 8'h00, 3'b000, 0, LDM, 2'b00, 2'b00, "load_mem_wait");
    applyStimulus(0, 8'h00, 3'b000, 1, LDM | REGW, 2'b00, 2'b00, "load_mem_done");
    exp_ret++;

    runMop(8'h40, 2'b00, "addm");
    runMop(8'h60, 2'b01, "andm");

    runJmp(8'hC8, 3'b010, 1'b1, "jz_taken");
    runJmp(8'hC8, 3'b000, 1'b0, "jz_not");
    runJmp(8'hD0, 3'b100, 1'b1, "jc_taken");
    runJmp(8'hD8, 3'b110, 1'b0, "jn_not");
    runJmp(8'hC0, 3'b000, 1'b1, "jmp_always");

    // Store completing on the very cycle the timer reaches its limit.
    applyStimulus(0, 8'h20, 3'b000, 1, FETCH, 2'b00, 2'b00, "st_if");
    applyStimulus(0, 8'h20, 3'b000, 0, 16'h0000, 2'b00, 2'b00, "st_id");
    for (int k = 0; k < 15; k++)
      applyStimulus(0, 8'h20, 3'b000, 0, STS, 2'b00, 2'b00, "st_wait");
    applyStimulus(0, 8'h20, 3'b000, 1, STS, 2'b00, 2'b00, "st_ready_at_limit");
    exp_ret++;

    applyStimulus(0, 8'h20, 3'b000, 1, FETCH, 2'b00, 2'b00, "sto_if");
    applyStimulus(0, 8'h20, 3'b000, 0, 16'h0000, 2'b00, 2'b00, "sto_id");
    for (int k = 0; k < 16; k++)
      applyStimulus(0, 8'h20, 3'b000, 0, STS, 2'b00, 2'b00, "sto_wait");
    applyStimulus(0, 8'h20, 3'b000, 0, 16'h0000, 2'b00, 2'b01, "fault_entry");
    applyStimulus(0, 8'h90, 3'b111, 1, 16'h0000, 2'b00, 2'b01, "fault_sticky1");
    applyStimulus(0, 8'hF0, 3'b000, 0, 16'h0000, 2'b00, 2'b01, "fault_sticky2");
    applyStimulus(1, 8'h00, 3'b000, 1, 16'h0000, 2'b00, 2'b00, "fault_rst");
    exp_ret = 16'h0000;

    applyStimulus(0, 8'hF0, 3'b000, 1, FETCH, 2'b00, 2'b00, "halt_if");
    applyStimulus(0, 8'hF0, 3'b000, 1, 16'h0000, 2'b00, 2'b00, "halt_id");
    exp_ret++;
    applyStimulus(0, 8'hF0, 3'b000, 1, 16'h0000, 2'b00, 2'b10, "halt_1");
    applyStimulus(0, 8'h90, 3'b010, 0, 16'h0000, 2'b00, 2'b10, "halt_2");
    applyStimulus(0, 8'h20, 3'b101, 1, 16'h0000, 2'b00, 2'b10, "halt_3");
    applyStimulus(1, 8'hF0, 3'b000, 1, 16'h0000, 2'b00, 2'b00, "halt_rst");
    exp_ret = 16'h0000;

    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 8'hE0, 3'b000, 1, FETCH, 2'b00, 2'b00, "di_if");
      applyStimulus(0, 8'hE0, 3'b000, 1, 16'h0000, 2'b00, 2'b00, "di_id");
      applyStimulus(0, 8'hE0, 3'b000, 1, DILD, 2'b00, 2'b00, "di_exec");
      exp_ret++;
    end
    applyStimulus(0, 8'hE0, 3'b000, 1, FETCH, 2'b00, 2'b00, "di_wrapped");

    repeat (2) @(posedge clk);
    if (expq.size() > 0) begin
      nerr++;
      $display("[TB] FAIL drain: %0d expected vectors left unchecked, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
